// File: rtl/step_sequencer_pkg.sv
// Shared types and defaults for the clock-enable step sequencer.
package step_sequencer_pkg;

  localparam int unsigned DIV_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF    = 8;
  localparam int unsigned MISS_LIM_DEF = 16;
  localparam int unsigned VAL_W        = 4;
  localparam int unsigned MODE_W       = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_CHECK  = 3'd2,
    ST_SINGLE = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_TARGET = 2'b10
  } mode_e;

  // The unused encoding 2'b11 behaves as free-run.
  function automatic mode_e decode_mode(input logic [MODE_W-1:0] raw);
    case (raw)
      2'b01:   return MODE_COUNT;
      2'b10:   return MODE_TARGET;
      default: return MODE_FREE;
    endcase
  endfunction

endpackage

// File: rtl/step_sequencer_prescaler.sv
// Divides the clock by DIV+1: counts 0..DIV, ticks while sitting at DIV.
// Holding at DIV (en low) keeps the tick pending until it is consumed.
module step_sequencer_prescaler #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_c1k,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick_c
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == i_div);

  // Prescaler count: clear, hold, or advance with wrap at DIV.
  always_ff @(posedge i_c1k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick_c ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Clock-enable sequencer for a 4-bit next-state counter: free-run, N steps,
// run-until-target, and single-step, with a DIV+1 prescaler on the CE rate.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned MISS_LIM = MISS_LIM_DEF
) (
  input  logic              i_c1k,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_stop,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [CNT_W-1:0]  i_n_steps,
  input  logic [VAL_W-1:0]  i_target,
  input  logic [DIV_W-1:0]  i_div,
  input  logic [VAL_W-1:0]  i_val,
  output logic              o_ce,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_miss,
  output logic [CNT_W-1:0]  o_step_cnt
);

  state_e             r_state;
  state_e             w_next;
  mode_e              r_mode;
  logic [CNT_W-1:0]   r_n_steps;
  logic [VAL_W-1:0]   r_target;
  logic [DIV_W-1:0]   r_div;
  logic [CNT_W-1:0]   r_step_cnt;
  logic               r_ce;
  logic               r_busy;
  logic               r_done;
  logic               r_miss;

  logic               w_latch;
  logic               w_cnt_clr;
  logic               w_cnt_one;
  logic               w_issue;
  logic               w_set_miss;
  logic               w_tick;
  logic               w_pre_clr;
  logic               w_pre_en;

  assign o_ce       = r_ce;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_miss     = r_miss;
  assign o_step_cnt = r_step_cnt;

  step_sequencer_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_c1k    (i_c1k),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_pre_clr),
    .i_en     (w_pre_en),
    .i_div    (r_div),
    .o_tick_c (w_tick)
  );

  // State register.
  always_ff @(posedge i_c1k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the per-cycle actions that feed the output registers.
  // Target mode starts in CHECK so a target already matched ends without a CE;
  // a CE issued from CHECK lands back in RUN, which then routes to CHECK again.
  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_one  = 1'b0;
    w_issue    = 1'b0;
    w_set_miss = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_latch   = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = (decode_mode(i_mode) == MODE_TARGET) ? ST_CHECK : ST_RUN;
        end else if (i_step) begin
          w_issue   = 1'b1;
          w_cnt_one = 1'b1;
          w_next    = ST_SINGLE;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_next = ST_FIN;
        end else if ((r_mode == MODE_COUNT) && (r_step_cnt == r_n_steps)) begin
          w_next = ST_FIN;
        end else if ((r_mode == MODE_TARGET) && r_ce) begin
          w_next = ST_CHECK;
        end else if (w_tick) begin
          w_issue = 1'b1;
        end
      end
      ST_CHECK: begin
        if (i_stop) begin
          w_next = ST_FIN;
        end else if (i_val == r_target) begin
          w_next = ST_FIN;
        end else if (r_step_cnt == CNT_W'(MISS_LIM)) begin
          w_set_miss = 1'b1;
          w_next     = ST_FIN;
        end else begin
          w_next  = ST_RUN;
          w_issue = w_tick;
        end
      end
      ST_SINGLE: begin
        w_next = ST_FIN;
      end
      ST_FIN: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Prescaler control: cleared while idle; a pending tick that was not
  // consumed as a CE holds at DIV instead of wrapping.
  always_comb begin
    w_pre_clr = (r_state == ST_IDLE);
    w_pre_en  = ((r_state == ST_RUN) || (r_state == ST_CHECK)) && (!w_tick || w_issue);
  end

  // Run configuration captured at START.
  always_ff @(posedge i_c1k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= MODE_FREE;
      r_n_steps <= '0;
      r_target  <= '0;
      r_div     <= '0;
    end else if (w_latch) begin
      r_mode    <= decode_mode(i_mode);
      r_n_steps <= i_n_steps;
      r_target  <= i_target;
      r_div     <= i_div;
    end
  end

  // Registered outputs and the saturating step counter.
  always_ff @(posedge i_c1k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_miss     <= 1'b0;
      r_step_cnt <= '0;
    end else begin
      r_ce   <= w_issue;
      r_busy <= (w_next == ST_RUN) || (w_next == ST_CHECK) || (w_next == ST_SINGLE);
      r_done <= (w_next == ST_FIN);
      if (w_latch) begin
        r_miss <= 1'b0;
      end else if (w_set_miss) begin
        r_miss <= 1'b1;
      end
      if (w_cnt_clr) begin
        r_step_cnt <= '0;
      end else if (w_cnt_one) begin
        r_step_cnt <= CNT_W'(1);
      end else if (w_issue && (r_step_cnt != '1)) begin
        r_step_cnt <= r_step_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: table of runs with a CE-cycle scoreboard, plus
// hand-written step, priority and reset sequences. Counter model 0->7->6->3->0.
module tb_step_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_step = 1'b0;
  logic       i_stop = 1'b0;
  logic [1:0] i_mode = 2'b00;
  logic [7:0] i_n_steps = 8'd0;
  logic [3:0] i_target = 4'd0;
  logic [7:0] i_div = 8'd0;
  logic [3:0] mdl_val = 4'd0;
  logic       mdl_clr = 1'b0;
  logic       o_ce;
  logic       o_busy;
  logic       o_done;
  logic       o_miss;
  logic [7:0] o_step_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] mode;
    int         div;
    int         n;
    int         tgt;
    int         stop_at;
    int         n_ce;
    int         first;
    int         per;
    int         done_cyc;
    int         cnt;
    int         miss;
  } vec_t;

  localparam int NVEC  = 11;
  localparam int BOUND = 80;
  vec_t vecs [NVEC];

  step_sequencer dut (
    .i_c1k      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_step     (i_step),
    .i_stop     (i_stop),
    .i_mode     (i_mode),
    .i_n_steps  (i_n_steps),
    .i_target   (i_target),
    .i_div      (i_div),
    .i_val      (mdl_val),
    .o_ce       (o_ce),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_miss     (o_miss),
    .o_step_cnt (o_step_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] mdl_next(input logic [3:0] v);
    case (v)
      4'd0:    return 4'd7;
      4'd7:    return 4'd6;
      4'd6:    return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  // Counter under control: advances on the edge that ends a CE cycle.
  always @(posedge clk) begin
    if (mdl_clr) mdl_val <= 4'd0;
    else if (o_ce) mdl_val <= mdl_next(mdl_val);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  q[$];
    bit  got_done;
    string tag;
    got_done = 1'b0;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk); mdl_clr = 1'b1;
    @(negedge clk); mdl_clr = 1'b0;
    for (int i = 0; i < v.n_ce; i++) q.push_back(v.first + i * v.per);
    i_mode    = v.mode;
    i_div     = 8'(v.div);
    i_n_steps = 8'(v.n);
    i_target  = 4'(v.tgt);
    i_start   = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int k = 0; k <= BOUND; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, " busy@0"}, int'(o_busy), 1);
      if (o_ce) begin
        if (q.size() == 0) chk({tag, " unexpected ce cycle"}, k, -1);
        else chk({tag, " ce cycle"}, k, q.pop_front());
      end
      if (o_done) begin
        chk({tag, " done cycle"}, k, v.done_cyc);
        chk({tag, " step_cnt"}, int'(o_step_cnt), v.cnt);
        chk({tag, " miss"}, int'(o_miss), v.miss);
        chk({tag, " busy@done"}, int'(o_busy), 0);
        got_done = 1'b1;
        break;
      end
      if (k == v.stop_at) i_stop = 1'b1;
    end
    i_stop = 1'b0;
    if (!got_done) chk({tag, " done timeout"}, 0, 1);
    chk({tag, " ce pending"}, q.size(), 0);
    @(negedge clk);
    chk({tag, " done pulse width"}, int'(o_done), 0);
    chk({tag, " miss hold"}, int'(o_miss), v.miss);
    chk({tag, " cnt hold"}, int'(o_step_cnt), v.cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            mode  div n  tgt stop nce first per done cnt miss
    vecs[0]  = '{2'b01, 2, 3, 0, -1,  3,  3,   3,  10,  3, 0};
    vecs[1]  = '{2'b01, 2, 0, 0, -1,  0,  0,   0,   1,  0, 0};
    vecs[2]  = '{2'b10, 3, 0, 0, -1,  0,  0,   0,   1,  0, 0};
    vecs[3]  = '{2'b10, 1, 0, 6, -1,  2,  2,   2,   6,  2, 0};
    vecs[4]  = '{2'b10, 0, 0, 5, -1, 16,  1,   2,  33, 16, 1};
    vecs[5]  = '{2'b01, 0, 4, 0, -1,  4,  1,   1,   5,  4, 0};
    vecs[6]  = '{2'b10, 2, 0, 3, -1,  3,  3,   3,  11,  3, 0};
    vecs[7]  = '{2'b01, 1, 5, 0, -1,  5,  2,   2,  11,  5, 0};
    vecs[8]  = '{2'b01, 2, 3, 0,  2,  0,  0,   0,   3,  0, 0};
    vecs[9]  = '{2'b11, 0, 0, 0,  4,  4,  1,   1,   5,  4, 0};
    vecs[10] = '{2'b10, 1, 0, 5,  3,  1,  2,   2,   4,  1, 0};

    // Reset values.
    #12;
    chk("rst ce", int'(o_ce), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst miss", int'(o_miss), 0);
    chk("rst step_cnt", int'(o_step_cnt), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Single step from IDLE.
    @(negedge clk); i_step = 1'b1;
    @(posedge clk); #1 i_step = 1'b0;
    @(negedge clk);
    chk("step ce", int'(o_ce), 1);
    chk("step busy", int'(o_busy), 1);
    chk("step cnt", int'(o_step_cnt), 1);
    @(negedge clk);
    chk("step ce off", int'(o_ce), 0);
    chk("step done", int'(o_done), 1);
    @(negedge clk);
    chk("step done off", int'(o_done), 0);
    chk("step no 2nd ce", int'(o_ce), 0);
    chk("step cnt hold", int'(o_step_cnt), 1);

    // START wins over STEP; N=0 finishes without a CE.
    @(negedge clk);
    i_mode = 2'b01; i_n_steps = 8'd0; i_div = 8'd0;
    i_start = 1'b1; i_step = 1'b1;
    @(posedge clk); #1 begin i_start = 1'b0; i_step = 1'b0; end
    @(negedge clk);
    chk("prio ce", int'(o_ce), 0);
    chk("prio cnt cleared", int'(o_step_cnt), 0);
    @(negedge clk);
    chk("prio done", int'(o_done), 1);
    chk("prio ce still off", int'(o_ce), 0);

    // Asynchronous reset during free-run.
    @(negedge clk);
    i_mode = 2'b00; i_div = 8'd0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("free ce", int'(o_ce), 1);
    chk("free cnt", int'(o_step_cnt), 4);
    rst_n = 1'b0;
    #1;
    chk("async rst ce", int'(o_ce), 0);
    chk("async rst busy", int'(o_busy), 0);
    chk("async rst cnt", int'(o_step_cnt), 0);
    @(negedge clk); rst_n = 1'b1;
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
